// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stage sequencer: FSM states and the priority-ordered
// control rules that the run state arbitrates between.
package pipe_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  // Lower value wins; RULE_NONE means the pipeline advances freely.
  typedef enum logic [2:0] {
    RULE_NONE   = 3'd0,
    RULE_MEM    = 3'd1,
    RULE_BRANCH = 3'd2,
    RULE_STALL  = 3'd3,
    RULE_JUMP   = 3'd4,
    RULE_IFETCH = 3'd5
  } rule_e;

  localparam int unsigned NUM_RULES = 5;

  function automatic rule_e pick_rule(input logic mem_hold, input logic branch_taken,
                                      input logic stall, input logic jump,
                                      input logic imem_ready);
    if (mem_hold)          return RULE_MEM;
    else if (branch_taken) return RULE_BRANCH;
    else if (stall)        return RULE_STALL;
    else if (jump)         return RULE_JUMP;
    else if (!imem_ready)  return RULE_IFETCH;
    else                   return RULE_NONE;
  endfunction

endpackage

// File: rtl/pipeline_stage_sequencer_if.sv
// Control bundle between the hazard/memory side of the core and the stage sequencer.
interface pipeline_stage_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             w_stall;
  logic             w_branch_taken;
  logic             w_jump;
  logic             w_dmem_req;
  logic             w_dmem_ready;
  logic             w_imem_ready;
  logic             w_halt_req;
  logic             w_pc_en;
  logic             w_fd_en;
  logic             w_de_en;
  logic             w_em_en;
  logic             w_mw_en;
  logic             w_fd_flush;
  logic             w_de_bubble;
  logic             w_mw_bubble;
  logic             w_halted;
  logic             w_timeout;
  logic [CNT_W-1:0] w_stall_count;
  logic [CNT_W-1:0] w_flush_count;

  modport master (
    output w_stall, w_branch_taken, w_jump, w_dmem_req, w_dmem_ready, w_imem_ready,
           w_halt_req,
    input  w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en, w_fd_flush, w_de_bubble,
           w_mw_bubble, w_halted, w_timeout, w_stall_count, w_flush_count
  );

  modport slave (
    input  w_stall, w_branch_taken, w_jump, w_dmem_req, w_dmem_ready, w_imem_ready,
           w_halt_req,
    output w_pc_en, w_fd_en, w_de_en, w_em_en, w_mw_en, w_fd_flush, w_de_bubble,
           w_mw_bubble, w_halted, w_timeout, w_stall_count, w_flush_count
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// Central F/D/E/M/W sequencer: arbitrates hazard, branch, jump and memory-wait requests into
// per-register enables plus flush/bubble controls, with a sticky timeout halt.
module pipeline_stage_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  pipeline_stage_sequencer_if.slave bus
);

  localparam int unsigned          WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic                halted_q, halted_d;

  logic  pc_en, fd_en, de_en, em_en, mw_en;
  logic  fd_flush, de_bubble, mw_bubble;
  logic  stall_inc, flush_inc, cnt_clear;
  logic  mem_hold;
  rule_e rule;

  always_comb begin
    pc_en      = 1'b0;
    fd_en      = 1'b0;
    de_en      = 1'b0;
    em_en      = 1'b0;
    mw_en      = 1'b0;
    fd_flush   = 1'b0;
    de_bubble  = 1'b0;
    mw_bubble  = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    halted_d   = halted_q;

    // While waiting, only ready matters; the request is assumed to stay asserted.
    if (state_q == S_MEM_WAIT) begin
      mem_hold = ~bus.w_dmem_ready;
    end else begin
      mem_hold = bus.w_dmem_req & ~bus.w_dmem_ready;
    end
    rule = pick_rule(mem_hold, bus.w_branch_taken, bus.w_stall, bus.w_jump,
                     bus.w_imem_ready);

    unique case (state_q)
      S_RESET: begin
        fd_flush   = 1'b1;
        de_bubble  = 1'b1;
        mw_bubble  = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_RUN;
      end

      S_RUN, S_MEM_WAIT: begin
        pc_en = 1'b1;
        fd_en = 1'b1;
        de_en = 1'b1;
        em_en = 1'b1;
        mw_en = 1'b1;
        unique case (rule)
          RULE_MEM: begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_en     = 1'b0;
            mw_bubble = 1'b1;
            stall_inc = 1'b1;
          end
          RULE_BRANCH: begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            flush_inc = 1'b1;
          end
          RULE_STALL: begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            stall_inc = 1'b1;
          end
          RULE_JUMP: begin
            fd_flush  = 1'b1;
            flush_inc = 1'b1;
          end
          RULE_IFETCH: begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
          end
          RULE_NONE: ;
          default: ;
        endcase

        if (state_q == S_RUN) begin
          if (rule == RULE_MEM) begin
            state_d    = S_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (bus.w_halt_req) begin
            pc_en    = 1'b0;
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        end else if (bus.w_dmem_ready) begin
          // Release cycle: halt_req is deliberately not honoured here.
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_HALT: ;

      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      halted_q   <= halted_d;
    end
  end

  assign cnt_clear = (state_q == S_RESET);

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .clear   (cnt_clear),
    .count   (bus.w_stall_count)
  );

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .clear   (cnt_clear),
    .count   (bus.w_flush_count)
  );

  assign bus.w_pc_en     = pc_en;
  assign bus.w_fd_en     = fd_en;
  assign bus.w_de_en     = de_en;
  assign bus.w_em_en     = em_en;
  assign bus.w_mw_en     = mw_en;
  assign bus.w_fd_flush  = fd_flush;
  assign bus.w_de_bubble = de_bubble;
  assign bus.w_mw_bubble = mw_bubble;
  assign bus.w_halted    = halted_q;
  assign bus.w_timeout   = timeout_q;

endmodule

// File: tb/tb_pipeline_stage_sequencer.sv
// Directed bench: a default-parameter sequencer plus a narrow-counter, short-timeout one
// for saturation and minimum-timeout corners.
module tb_pipeline_stage_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pipeline_stage_sequencer_if #(.CNT_W(32)) ifa ();
  pipeline_stage_sequencer_if #(.CNT_W(3))  ifb ();

  pipeline_stage_sequencer #(
    .CNT_W       (32),
    .MEM_TIMEOUT (16)
  ) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  pipeline_stage_sequencer #(
    .CNT_W       (3),
    .MEM_TIMEOUT (2)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  // {pc, fd, de, em, mw} and {fd_flush, de_bubble, mw_bubble}, zero-extended for the checker
  logic [31:0] en_a, fl_a, sc_a, fc_a, hl_a, to_a, sc_b, hl_b, to_b;
  assign en_a = {27'd0, ifa.w_pc_en, ifa.w_fd_en, ifa.w_de_en, ifa.w_em_en, ifa.w_mw_en};
  assign fl_a = {29'd0, ifa.w_fd_flush, ifa.w_de_bubble, ifa.w_mw_bubble};
  assign sc_a = ifa.w_stall_count;
  assign fc_a = ifa.w_flush_count;
  assign hl_a = {31'd0, ifa.w_halted};
  assign to_a = {31'd0, ifa.w_timeout};
  assign sc_b = {29'd0, ifb.w_stall_count};
  assign hl_b = {31'd0, ifb.w_halted};
  assign to_b = {31'd0, ifb.w_timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    ifa.w_stall        = 1'b0;
    ifa.w_branch_taken = 1'b0;
    ifa.w_jump         = 1'b0;
    ifa.w_dmem_req     = 1'b0;
    ifa.w_dmem_ready   = 1'b0;
    ifa.w_imem_ready   = 1'b1;
    ifa.w_halt_req     = 1'b0;
  endtask

  task automatic idle_b();
    ifb.w_stall        = 1'b0;
    ifb.w_branch_taken = 1'b0;
    ifb.w_jump         = 1'b0;
    ifb.w_dmem_req     = 1'b0;
    ifb.w_dmem_ready   = 1'b0;
    ifb.w_imem_ready   = 1'b1;
    ifb.w_halt_req     = 1'b0;
  endtask

  initial begin
    idle_a();
    idle_b();
    reset_n = 1'b0;

    // Reset held for three cycles
    repeat (3) tick();
    #2;
    check("rst_en", en_a, 32'h00);
    check("rst_fl", fl_a, 32'h7);
    check("rst_sc", sc_a, 32'd0);
    check("rst_fc", fc_a, 32'd0);
    check("rst_halt", hl_a, 32'd0);
    check("rst_to", to_a, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_rel_en", en_a, 32'h00);
    tick();
    #2;
    check("run_en", en_a, 32'h1f);
    check("run_fl", fl_a, 32'h0);

    // Two-cycle hazard stall
    ifa.w_stall = 1'b1;
    #2;
    check("stall1_en", en_a, 32'h07);
    check("stall1_fl", fl_a, 32'h2);
    tick();
    #2;
    check("stall2_en", en_a, 32'h07);
    check("stall2_fl", fl_a, 32'h2);
    tick();
    ifa.w_stall = 1'b0;
    #2;
    check("stall_sc", sc_a, 32'd2);
    check("stall_fc", fc_a, 32'd0);

    // Branch beats stall
    ifa.w_branch_taken = 1'b1;
    ifa.w_stall        = 1'b1;
    #2;
    check("br_en", en_a, 32'h1f);
    check("br_fl", fl_a, 32'h6);
    tick();
    idle_a();
    #2;
    check("br_fc", fc_a, 32'd1);
    check("br_sc", sc_a, 32'd2);

    // Memory wait of three cycles, then ready
    ifa.w_dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("mw_en", en_a, 32'h01);
      check("mw_fl", fl_a, 32'h1);
      tick();
    end
    ifa.w_dmem_ready = 1'b1;
    #2;
    check("mw_rdy_en", en_a, 32'h1f);
    check("mw_rdy_fl", fl_a, 32'h0);
    tick();
    idle_a();
    #2;
    check("mw_sc", sc_a, 32'd5);

    // Memory never ready: halt with timeout after 16 waiting cycles
    ifa.w_dmem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #2;
      check("to_wait_en", en_a, 32'h01);
      check("to_wait_halt", hl_a, 32'd0);
      tick();
    end
    #2;
    check("to_halt", hl_a, 32'd1);
    check("to_flag", to_a, 32'd1);
    check("to_en", en_a, 32'h00);
    check("to_fl", fl_a, 32'h0);
    check("to_sc", sc_a, 32'd21);
    idle_a();
    ifa.w_dmem_ready = 1'b1;
    repeat (3) tick();
    #2;
    check("to_sticky_halt", hl_a, 32'd1);
    check("to_sticky_to", to_a, 32'd1);
    check("to_sticky_en", en_a, 32'h00);

    // Async reset out of halt
    reset_n = 1'b0;
    #2;
    check("rst2_halt", hl_a, 32'd0);
    check("rst2_to", to_a, 32'd0);
    check("rst2_sc", sc_a, 32'd0);
    idle_a();
    tick();
    reset_n = 1'b1;
    tick();

    // Halt request
    ifa.w_halt_req = 1'b1;
    #2;
    check("hreq_en", en_a, 32'h0f);
    check("hreq_fl", fl_a, 32'h0);
    tick();
    ifa.w_halt_req = 1'b0;
    #2;
    check("hreq_halt", hl_a, 32'd1);
    check("hreq_en_off", en_a, 32'h00);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Jump, stall-over-jump, fetch wait
    ifa.w_jump = 1'b1;
    #2;
    check("jmp_en", en_a, 32'h1f);
    check("jmp_fl", fl_a, 32'h4);
    tick();
    ifa.w_stall = 1'b1;
    #2;
    check("sj_en", en_a, 32'h07);
    check("sj_fl", fl_a, 32'h2);
    tick();
    idle_a();
    ifa.w_imem_ready = 1'b0;
    #2;
    check("if_en", en_a, 32'h0f);
    check("if_fl", fl_a, 32'h4);
    tick();
    ifa.w_imem_ready = 1'b1;
    #2;
    check("jmp_fc", fc_a, 32'd1);
    check("jmp_sc", sc_a, 32'd1);

    // Halt request ignored on the memory-release cycle
    ifa.w_dmem_req = 1'b1;
    tick();
    ifa.w_dmem_ready = 1'b1;
    ifa.w_halt_req   = 1'b1;
    #2;
    check("rel_halt_en", en_a, 32'h1f);
    tick();
    idle_a();
    #2;
    check("rel_halt_halted", hl_a, 32'd0);
    check("rel_halt_run", en_a, 32'h1f);
    check("rel_halt_sc", sc_a, 32'd2);

    // Narrow counter saturates at all-ones
    ifb.w_stall = 1'b1;
    repeat (6) tick();
    #2;
    check("sat_pre", sc_b, 32'd6);
    repeat (3) tick();
    #2;
    check("sat_hold", sc_b, 32'd7);
    idle_b();

    // Minimum timeout of two cycles
    ifb.w_dmem_req = 1'b1;
    tick();
    #2;
    check("b_to_wait", hl_b, 32'd0);
    tick();
    #2;
    check("b_to_halt", hl_b, 32'd1);
    check("b_to_flag", to_b, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
